// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: stall vector layout,
// canned stall patterns and the divider FSM state encoding.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W   = 6;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EXE = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE = '0;
  // Load-use freezes PC/IF/ID and lets EX take a bubble.
  localparam logic [STALL_W-1:0] STALL_LU   = STALL_W'((1 << STALL_PC) | (1 << STALL_IF) |
                                                       (1 << STALL_ID));
  // Divider holds its instruction in EX as well.
  localparam logic [STALL_W-1:0] STALL_EX   = STALL_LU | STALL_W'(1 << STALL_EXE);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Combinational load-use comparator: an ID operand needs the register a load
// in EX will write, and forwarding cannot help because EX only holds the address.
module pipe_stall_ctrl_hazard_detect (
  input  logic       i_id_re1,
  input  logic [4:0] i_id_raddr1,
  input  logic       i_id_re2,
  input  logic [4:0] i_id_raddr2,
  input  logic       i_ex_is_load,
  input  logic       i_ex_wreg,
  input  logic [4:0] i_ex_waddr,
  output logic       o_load_use
);

  logic w_ex_load_wr;
  logic w_hit1;
  logic w_hit2;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign w_ex_load_wr = i_ex_is_load & i_ex_wreg & (i_ex_waddr != 5'd0);
  assign w_hit1       = i_id_re1 & (i_id_raddr1 == i_ex_waddr);
  assign w_hit2       = i_id_re2 & (i_id_raddr2 == i_ex_waddr);
  assign o_load_use   = w_ex_load_wr & (w_hit1 | w_hit2);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard sequencer: load-use bubble, divider start/ready sequencing
// with watchdog, flush handling. Optional perf counters under STALL_PERF_CNT_EN.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40,
  parameter int TMO_W       = 6
`ifdef STALL_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_re1,
  input  logic [4:0]         id_raddr1,
  input  logic               id_re2,
  input  logic [4:0]         id_raddr2,
  input  logic               ex_is_load,
  input  logic               ex_wreg,
  input  logic [4:0]         ex_waddr,
  input  logic               ex_div_req,
  input  logic               div_ready,
  input  logic               flush,
  output logic [STALL_W-1:0] stall,
  output logic               div_start,
  output logic               div_cancel,
  output logic               div_timeout,
  output logic               load_use
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   perf_lu_cnt,
  output logic [CNT_W-1:0]   perf_div_cnt
`endif
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DIV_TIMEOUT - 1);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [TMO_W-1:0] r_tmo;
  logic             w_lu_raw;
  logic             w_div_stall;

  pipe_stall_ctrl_hazard_detect u_hazard_detect (
    .i_id_re1     (id_re1),
    .i_id_raddr1  (id_raddr1),
    .i_id_re2     (id_re2),
    .i_id_raddr2  (id_raddr2),
    .i_ex_is_load (ex_is_load),
    .i_ex_wreg    (ex_wreg),
    .i_ex_waddr   (ex_waddr),
    .o_load_use   (w_lu_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= (r_state == DIV_BUSY && w_state_nxt == DIV_BUSY) ? r_tmo + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_stall = 1'b0;
    div_start   = 1'b0;
    div_cancel  = 1'b0;
    div_timeout = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (ex_div_req) begin
          div_start   = 1'b1;
          w_div_stall = 1'b1;
          w_state_nxt = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (div_ready) begin
          w_div_stall = 1'b1;
          w_state_nxt = DIV_DONE;
        end else if (r_tmo == TMO_LAST) begin
          div_timeout = 1'b1;
          w_state_nxt = DIV_IDLE;
        end else begin
          w_div_stall = 1'b1;
        end
      end
      // One unstalled cycle lets the divide leave EX; a pending request waits.
      DIV_DONE: w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase

    if (flush) begin
      w_div_stall = 1'b0;
      div_start   = 1'b0;
      div_timeout = 1'b0;
      div_cancel  = (r_state == DIV_BUSY);
      w_state_nxt = DIV_IDLE;
    end

    // Reset silences even the combinational outputs and never reports a cancel.
    if (rst) begin
      w_div_stall = 1'b0;
      div_start   = 1'b0;
      div_timeout = 1'b0;
      div_cancel  = 1'b0;
      w_state_nxt = DIV_IDLE;
    end
  end

  always_comb begin
    stall    = STALL_NONE;
    load_use = 1'b0;
    if (!rst && !flush) begin
      if (w_div_stall) begin
        stall = STALL_EX;
      end else if (w_lu_raw) begin
        stall    = STALL_LU;
        load_use = 1'b1;
      end
    end
  end

`ifdef STALL_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lu_cnt  <= '0;
      r_div_cnt <= '0;
    end else begin
      if (load_use)    r_lu_cnt  <= sat_inc(r_lu_cnt);
      if (w_div_stall) r_div_cnt <= sat_inc(r_div_cnt);
    end
  end

  assign perf_lu_cnt  = r_lu_cnt;
  assign perf_div_cnt = r_div_cnt;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed cycles push hand-computed
// expected outputs; a negedge monitor pops and compares every cycle.
module tb_pipe_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       id_re1;
  logic [4:0] id_raddr1;
  logic       id_re2;
  logic [4:0] id_raddr2;
  logic       ex_is_load;
  logic       ex_wreg;
  logic [4:0] ex_waddr;
  logic       ex_div_req;
  logic       div_ready;
  logic       flush;
  logic [5:0] stall;
  logic       div_start;
  logic       div_cancel;
  logic       div_timeout;
  logic       load_use;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_lu_cnt;
  logic [31:0] perf_div_cnt;
`endif

  pipe_stall_ctrl #(.DIV_TIMEOUT(40), .TMO_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_re1      (id_re1),
    .id_raddr1   (id_raddr1),
    .id_re2      (id_re2),
    .id_raddr2   (id_raddr2),
    .ex_is_load  (ex_is_load),
    .ex_wreg     (ex_wreg),
    .ex_waddr    (ex_waddr),
    .ex_div_req  (ex_div_req),
    .div_ready   (div_ready),
    .flush       (flush),
    .stall       (stall),
    .div_start   (div_start),
    .div_cancel  (div_cancel),
    .div_timeout (div_timeout),
    .load_use    (load_use)
`ifdef STALL_PERF_CNT_EN
    ,
    .perf_lu_cnt (perf_lu_cnt),
    .perf_div_cnt(perf_div_cnt)
`endif
  );

  typedef struct {
    logic [9:0] exp;
    int         step;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   step_id;
  int   mon_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: outputs are valid every cycle, so one expectation is consumed per cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [9:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {stall, div_start, div_cancel, div_timeout, load_use};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL step%0d cyc%0d {stall,start,cancel,tmo,lu} got %b_%b%b%b%b want %b_%b%b%b%b",
                 e.step, mon_cyc, act[9:4], act[3], act[2], act[1], act[0],
                 e.exp[9:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
      end
      mon_cyc++;
    end
  end

  task automatic cyc(input logic [5:0] s, input logic st, input logic ca,
                     input logic tm, input logic lu);
    exp_t e;
    e.exp  = {s, st, ca, tm, lu};
    e.step = step_id;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_re1     = 1'b0;
    id_raddr1  = 5'd0;
    id_re2     = 1'b0;
    id_raddr2  = 5'd0;
    ex_is_load = 1'b0;
    ex_wreg    = 1'b0;
    ex_waddr   = 5'd0;
    ex_div_req = 1'b0;
    div_ready  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic set_lu_hazard(input logic [4:0] r);
    ex_is_load = 1'b1;
    ex_wreg    = 1'b1;
    ex_waddr   = r;
    id_re1     = 1'b1;
    id_raddr1  = r;
  endtask

  localparam logic [5:0] S0  = 6'b000000;
  localparam logic [5:0] SLU = 6'b000111;
  localparam logic [5:0] SEX = 6'b001111;

  initial begin
    checks  = 0;
    errors  = 0;
    step_id = 0;
    mon_cyc = 0;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset dominates live hazard and divide request.
    step_id = 1;
    set_lu_hazard(5'd5);
    ex_div_req = 1'b1;
    cyc(S0, 0, 0, 0, 0);
    cyc(S0, 0, 0, 0, 0);
    rst = 1'b0;
    clear_inputs();
    cyc(S0, 0, 0, 0, 0);

    // Load-use on operand 1, then cleared as the load moves on.
    step_id = 2;
    set_lu_hazard(5'd5);
    cyc(SLU, 0, 0, 0, 1);
    ex_is_load = 1'b0;
    cyc(S0, 0, 0, 0, 0);
    set_lu_hazard(5'd0);
    cyc(S0, 0, 0, 0, 0);

    // Operand 2 path, read-enable gating, and non-writing load.
    step_id = 3;
    clear_inputs();
    ex_is_load = 1'b1; ex_wreg = 1'b1; ex_waddr = 5'd9;
    id_re2 = 1'b1; id_raddr2 = 5'd9;
    cyc(SLU, 0, 0, 0, 1);
    id_re2 = 1'b0;
    cyc(S0, 0, 0, 0, 0);
    id_re2 = 1'b1; ex_wreg = 1'b0;
    cyc(S0, 0, 0, 0, 0);
    ex_wreg = 1'b1; id_raddr2 = 5'd10;
    cyc(S0, 0, 0, 0, 0);

    // Flush in IDLE suppresses div_start and load_use.
    step_id = 4;
    clear_inputs();
    set_lu_hazard(5'd3);
    ex_div_req = 1'b1;
    flush      = 1'b1;
    cyc(S0, 0, 0, 0, 0);

    // Nominal divide: ready 33 cycles after start, then DONE, then back-to-back start.
    step_id = 5;
    clear_inputs();
    ex_div_req = 1'b1;
    cyc(SEX, 1, 0, 0, 0);
    for (int i = 1; i <= 32; i++) cyc(SEX, 0, 0, 0, 0);
    div_ready = 1'b1;
    cyc(SEX, 0, 0, 0, 0);
    div_ready = 1'b0;
    cyc(S0, 0, 0, 0, 0);
    step_id = 6;
    cyc(SEX, 1, 0, 0, 0);

    // Flush at BUSY cycle 10 cancels; late div_ready in IDLE is ignored.
    step_id = 7;
    ex_div_req = 1'b0;
    for (int i = 1; i <= 9; i++) cyc(SEX, 0, 0, 0, 0);
    flush = 1'b1;
    cyc(S0, 0, 1, 0, 0);
    flush     = 1'b0;
    div_ready = 1'b1;
    cyc(S0, 0, 0, 0, 0);
    div_ready = 1'b0;
    cyc(S0, 0, 0, 0, 0);

    // Watchdog: start, 39 stalled BUSY cycles, timeout pulse on the 40th.
    step_id = 8;
    ex_div_req = 1'b1;
    cyc(SEX, 1, 0, 0, 0);
    ex_div_req = 1'b0;
    for (int i = 1; i <= 39; i++) cyc(SEX, 0, 0, 0, 0);
    cyc(S0, 0, 0, 1, 0);
    cyc(S0, 0, 0, 0, 0);

    // Divide and load-use together: divider stall wins, load_use masked.
    step_id = 9;
    set_lu_hazard(5'd7);
    ex_div_req = 1'b1;
    cyc(SEX, 1, 0, 0, 0);
    ex_div_req = 1'b0;
    cyc(SEX, 0, 0, 0, 0);
    cyc(SEX, 0, 0, 0, 0);

    // Reset mid-BUSY: silent, no cancel, and IDLE afterwards (load-use visible again).
    step_id = 10;
    rst = 1'b1;
    cyc(S0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(SLU, 0, 0, 0, 1);
    clear_inputs();
    cyc(S0, 0, 0, 0, 0);

    // Drain the scoreboard; anything left over is a missed comparison.
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Hazard sequencer for the 5-stage pipeline; sits beside the ID-stage register file and its EX/MEM/WB forwarding paths.
- Covers the one hazard forwarding cannot resolve: load-use, where EX holds an address rather than data. It inserts a one-cycle bubble for it.
- Sequences the multi-cycle divider in EX through a start/ready handshake with a timeout watchdog.
- Drives the per-stage stall vector and honours a pipeline flush.

Parameters:
- DIV_TIMEOUT, 40: max BUSY cycles before the watchdog aborts the divide.
- TMO_W, 6: width of the watchdog counter; must satisfy 2^TMO_W > DIV_TIMEOUT.
- CNT_W, 32: width of the perf counters (optional feature only).

Ports:
- clk  in  1  clock; synchronous active-high reset `rst`, all state updates on posedge clk.
- rst  in  1  synchronous reset, active high.
- id_re1  in  1  ID reads operand 1.
- id_raddr1  in  5  operand 1 register address.
- id_re2  in  1  ID reads operand 2.
- id_raddr2  in  5  operand 2 register address.
- ex_is_load  in  1  EX instruction is a load.
- ex_wreg  in  1  EX instruction writes a register.
- ex_waddr  in  5  EX destination register.
- ex_div_req  in  1  EX instruction needs the divider.
- div_ready  in  1  divider result valid (single-cycle pulse).
- flush  in  1  exception/redirect flush.
- stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- div_start  out  1  one-cycle divider launch pulse.
- div_cancel  out  1  one-cycle divider abort pulse.
- div_timeout  out  1  one-cycle watchdog-expired pulse.
- load_use  out  1  load-use bubble inserted this cycle.

Behaviour:
- Reset: state IDLE, watchdog counter 0. All outputs 0 in the cycle `rst` is high, including combinational ones.
- Load-use condition (combinational), asserted when all hold:
  - ex_is_load & ex_wreg & ex_waddr != 0;
  - (id_re1 & id_raddr1 == ex_waddr) | (id_re2 & id_raddr2 == ex_waddr).
- Load-use response: stall = 6'b000111 and load_use = 1. EX receives a bubble; the hazard clears the next cycle, when the load is in MEM and forwarding supplies the data.
- Register 0 never causes a hazard.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE: if ex_div_req & !flush, then div_start = 1, stall = 6'b001111, next state BUSY, counter cleared.
  - BUSY: stall = 6'b001111 and the counter increments each cycle.
    - div_ready: next state DONE.
    - Counter reaches DIV_TIMEOUT-1 without div_ready: div_timeout = 1, next state IDLE, stall released that cycle.
  - DONE: stall = 0 for exactly one cycle so the div instruction leaves EX; ex_div_req is ignored; next state IDLE.
- A back-to-back divide restarts from IDLE on the following cycle, so div_start fires again.
- div_ready in IDLE or DONE is ignored.
- Priority: flush > divider > load-use.
- flush, any state: stall = 0, next state IDLE; div_cancel = 1 if the state was BUSY.
- div_start and load_use are suppressed while flush is high.
- Divider stall and load-use together: stall = 6'b001111; load_use = 0; the hazard is re-evaluated when the stall releases.
- stall, load_use and div_start are combinational from inputs and state; div_cancel and div_timeout are also combinational.
- Latency: the stall appears in the same cycle as the detecting condition.
- Reset asserted mid-BUSY: IDLE next cycle, no div_cancel pulse.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined: adds outputs perf_lu_cnt[CNT_W-1:0] and perf_div_cnt[CNT_W-1:0].
  - perf_lu_cnt counts cycles with load_use = 1.
  - perf_div_cnt counts cycles stalled by the divider.
  - Both saturate at all-ones and clear on rst.
- Not defined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package/defines.vh holds:
  - STALL_W = 6;
  - stall bit indices STALL_PC..STALL_WB;
  - constant vectors STALL_NONE = 6'b000000, STALL_LU = 6'b000111, STALL_EX = 6'b001111;
  - FSM state encodings DIV_IDLE/DIV_BUSY/DIV_DONE.
- One sub-module is natural: hazard_detect, the combinational load-use comparator.
- The FSM and stall mux stay in the top module.

Test Plan:
- Load-use: ex_is_load=1, ex_wreg=1, ex_waddr=5, id_re1=1, id_raddr1=5 -> stall=000111, load_use=1 for one cycle. Repeat with ex_waddr=0 -> stall=000000.
- Divide nominal: ex_div_req held, div_ready pulses 33 cycles after div_start -> div_start in cycle 0, stall=001111 for 34 cycles, one DONE cycle with stall=000000, then IDLE.
- Back-to-back divides: ex_div_req stays high after DONE -> second div_start in the cycle after DONE.
- Timeout: DIV_TIMEOUT=40, div_ready never asserted -> div_timeout pulse 40 cycles after entering BUSY, state IDLE, stall released that cycle.
- Flush mid-BUSY at cycle 10 -> div_cancel=1, stall=000000 that cycle, IDLE next cycle. A later div_ready arriving while IDLE causes no state change.
- Simultaneous divide and load-use: div stall 001111 dominates, load_use=0. rst asserted during BUSY -> all outputs 0, IDLE next cycle, no div_cancel.
